// File: rtl/md_scheduler.sv
// ---------------------------------------------------------------------------
// md_scheduler
//
// Execute-stage multiply/divide sequencer. Owns the architectural HI/LO pair,
// runs mult/multu/div/divu with a fixed multi-cycle latency, and raises the
// decode-stage stall for any MD-class instruction while the unit is occupied.
// The full result is computed in the launch cycle and parked in temporary
// registers; HI/LO only change when the busy window closes.
//
// Optional feature (macro MD_SCHEDULER_MADD_EN):
//   defined   -> mdOp 9 (madd) / 10 (maddu) accumulate the product into
//                {hi,lo} with MULT_CYCLES latency (64-bit wrap).
//   undefined -> mdOp 9 / 10 behave as "none".
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu/madd/maddu (1..15)
//   DIV_CYCLES   busy cycles for div/divu (1..15)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   mdOp     in   E-stage MD operation code
//   start    in   E-stage instruction valid (not a bubble)
//   srcA     in   rs operand (forwarded)
//   srcB     in   rt operand (forwarded)
//   dMD      in   D-stage instruction is MD-class
//   busy     out  unit is running an operation
//   mdStall  out  stall request to the D stage
//   mdOut    out  HI/LO read data for mfhi/mflo (committed values only)
//   hi, lo   out  architectural HI / LO
// ---------------------------------------------------------------------------
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdOp,
  input  logic        start,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        dMD,
  output logic        busy,
  output logic        mdStall,
  output logic [31:0] mdOut,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10
  } md_op_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] temp_hi_q, temp_hi_d;
  logic [31:0] temp_lo_q, temp_lo_d;

  // Operation decode
  logic is_mul, is_div, is_madd, is_arith, launch;

  assign is_mul = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
  assign is_div = (mdOp == OP_DIV)  || (mdOp == OP_DIVU);
`ifdef MD_SCHEDULER_MADD_EN
  assign is_madd = (mdOp == OP_MADD) || (mdOp == OP_MADDU);
`else
  assign is_madd = 1'b0;
`endif
  assign is_arith = is_mul || is_div || is_madd;
  assign launch   = start && (state_q == IDLE) && is_arith;

  // Multiply: sign-extending both operands to 64 bits makes the low 64 bits
  // of an unsigned 64x64 product equal to the signed 32x32 product.
  logic [63:0] a_sext, b_sext, prod_s, prod_u, prod;

  assign a_sext = {{32{srcA[31]}}, srcA};
  assign b_sext = {{32{srcB[31]}}, srcB};
  assign prod_s = a_sext * b_sext;
  assign prod_u = {32'd0, srcA} * {32'd0, srcB};
  assign prod   = ((mdOp == OP_MULT) || (mdOp == OP_MADD)) ? prod_s : prod_u;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero
  // and the remainder takes the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 with no special case.
  logic        div_signed, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign div_signed = (mdOp == OP_DIV);
  assign div_zero   = (srcB == 32'd0);
  assign a_mag      = (div_signed && srcA[31]) ? (32'd0 - srcA) : srcA;
  assign b_mag      = (div_signed && srcB[31]) ? (32'd0 - srcB) : srcB;
  // Substitute divisor keeps the divider's inputs defined; its output is
  // discarded on divide-by-zero.
  assign b_safe     = div_zero ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (div_signed && (srcA[31] ^ srcB[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem        = (div_signed && srcA[31]) ? (32'd0 - r_mag) : r_mag;

  // Result captured at launch. Divide-by-zero parks the current HI/LO, which
  // cannot change while RUN, so the commit leaves them untouched.
  logic [31:0] res_hi, res_lo;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    if (is_mul) begin
      {res_hi, res_lo} = prod;
    end else if (is_div && !div_zero) begin
      res_hi = rem;
      res_lo = quot;
    end
`ifdef MD_SCHEDULER_MADD_EN
    else if (is_madd) begin
      {res_hi, res_lo} = {hi_q, lo_q} + prod;
    end
`endif
  end

  // Next-state / datapath update
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          temp_hi_d = res_hi;
          temp_lo_d = res_lo;
          count_d   = is_div ? DIV_LOAD : MULT_LOAD;
          state_d   = RUN;
        end else if (start && (mdOp == OP_MTHI)) begin
          hi_d = srcA;
        end else if (start && (mdOp == OP_MTLO)) begin
          lo_d = srcA;
        end
      end
      RUN: begin
        // Any start seen here is ignored; only the countdown advances.
        if (count_q <= 4'd1) begin
          hi_d    = temp_hi_q;
          lo_d    = temp_lo_q;
          count_d = 4'd0;
          state_d = IDLE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // The temporaries are reset along with HI/LO so a reset mid-operation
  // leaves no stale result behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
    end
  end

  // Outputs
  assign busy    = (state_q == RUN);
  assign mdStall = dMD && (busy || launch);
  assign hi      = hi_q;
  assign lo      = lo_q;

  always_comb begin
    mdOut = 32'd0;
    if (mdOp == OP_MFHI) begin
      mdOut = hi_q;
    end else if (mdOp == OP_MFLO) begin
      mdOut = lo_q;
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// ---------------------------------------------------------------------------
// tb_md_scheduler
//
// Self-checking bench for md_scheduler. A behavioural model computes HI/LO
// with plain 64-bit arithmetic; each launched operation pushes its expected
// HI/LO and busy length into a scoreboard queue, and a monitor pops and
// compares whenever busy falls. Directed cases cover the documented examples
// and corner cases; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_md_scheduler;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdOp;
  logic        start;
  logic [31:0] srcA, srcB;
  logic        dMD;
  logic        busy, mdStall;
  logic [31:0] mdOut, hi, lo;

  md_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset   (reset),
    .mdOp    (mdOp),
    .start   (start),
    .srcA    (srcA),
    .srcB    (srcB),
    .dMD     (dMD),
    .busy    (busy),
    .mdStall (mdStall),
    .mdOut   (mdOut),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: architectural effect of one instruction issued while idle.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                output bit launch, output int lat,
                                output logic [31:0] nh, output logic [31:0] nl);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    launch = 1'b0;
    lat    = 0;
    nh     = cur_hi;
    nl     = cur_lo;
    sa     = longint'($signed(a));
    sbv    = longint'($signed(b));
    case (op)
      4'd1: begin launch = 1; lat = MULT_N; p = sa * sbv; {nh, nl} = p; end
      4'd2: begin launch = 1; lat = MULT_N; p = {32'd0, a} * {32'd0, b}; {nh, nl} = p; end
      4'd3: begin
        launch = 1; lat = DIV_N;
        if (b != 32'd0) begin
          q  = sa / sbv;
          r  = sa % sbv;
          nl = q[31:0];
          nh = r[31:0];
        end
      end
      4'd4: begin
        launch = 1; lat = DIV_N;
        if (b != 32'd0) begin
          nl = a / b;
          nh = a % b;
        end
      end
      4'd7: nh = a;
      4'd8: nl = a;
`ifdef MD_SCHEDULER_MADD_EN
      4'd9: begin launch = 1; lat = MULT_N; p = sa * sbv; {nh, nl} = {cur_hi, cur_lo} + p; end
      4'd10: begin
        launch = 1; lat = MULT_N;
        p = {32'd0, a} * {32'd0, b};
        {nh, nl} = {cur_hi, cur_lo} + p;
      end
`endif
      default: ;
    endcase
  endfunction

  // Issue one instruction from idle and follow it to completion. With
  // interfere set, extra starts are driven during the busy window.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic dmd, input bit interfere);
    bit          launch;
    int          lat;
    logic [31:0] nh, nl;
    exp_t        e;
    model(op, a, b, m_hi, m_lo, launch, lat, nh, nl);
    @(posedge clk); #1;
    start = 1'b1; mdOp = op; srcA = a; srcB = b; dMD = dmd;
    #1;
    check("stall_issue", {31'd0, mdStall}, {31'd0, dmd & launch});
    if (op == 4'd5)      check("mfhi", mdOut, m_hi);
    else if (op == 4'd6) check("mflo", mdOut, m_lo);
    else                 check("mdout_zero", mdOut, 32'd0);
    if (launch) begin
      e.hi = nh; e.lo = nl; e.cycles = lat;
      sb.push_back(e);
      for (int i = 1; i <= lat; i++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (interfere && i == 2) begin
          start = 1'b1; mdOp = 4'd1; srcA = $urandom; srcB = $urandom;
        end
        if (interfere && i == 3) begin
          start = 1'b1; mdOp = 4'd7; srcA = $urandom;
        end
        #1;
        check("busy_run", {31'd0, busy}, {31'd0, 1'b1});
        check("stall_run", {31'd0, mdStall}, {31'd0, dmd});
        check("hold_hi", hi, m_hi);
        check("hold_lo", lo, m_lo);
      end
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      check("busy_done", {31'd0, busy}, 32'd0);
      check("stall_done", {31'd0, mdStall}, 32'd0);
    end else begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      check("busy_idle", {31'd0, busy}, 32'd0);
    end
    check("hi_after", hi, nh);
    check("lo_after", lo, nl);
    m_hi = nh;
    m_lo = nl;
    dMD  = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever busy falls.
  bit prev_busy = 1'b0;
  int busy_cnt  = 0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: busy fell with no pending result");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_hi", hi, e.hi);
          check("sb_lo", lo, e.lo);
          check("sb_cycles", busy_cnt, e.cycles);
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  // Abort mid-divide with an asynchronous reset during the third busy cycle.
  task automatic reset_mid_div();
    @(posedge clk); #1;
    start = 1'b1; mdOp = 4'd3; srcA = 32'h0000_0064; srcB = 32'h0000_0007; dMD = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", {31'd0, mdStall}, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk); #2;
    reset = 1'b1;
    dMD   = 1'b0;
    @(posedge clk); #2;
    check("post_reset_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] op_tab [13];
    op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};
    reset = 1'b0; start = 1'b0; mdOp = 4'd0; srcA = 32'd0; srcB = 32'd0; dMD = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_stall", {31'd0, mdStall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dMD   = 1'b0;

    // Documented examples
    do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);   // mult -2*3, stall tracked
    do_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);   // multu
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);   // div -7/2
    do_op(4'd7, 32'd1, 32'd0, 1'b1, 1'b0);           // mthi 1
    do_op(4'd8, 32'd2, 32'd0, 1'b0, 1'b0);           // mtlo 2
    do_op(4'd4, 32'd7, 32'd0, 1'b1, 1'b0);           // divu by zero
    do_op(4'd7, 32'h1234_5678, 32'd0, 1'b0, 1'b0);   // mthi
    do_op(4'd5, 32'd0, 32'd0, 1'b1, 1'b0);           // mfhi
    do_op(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);           // mflo
    do_op(4'd1, 32'h0001_0003, 32'hFFFF_0005, 1'b1, 1'b1);  // starts while busy ignored
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);  // signed overflow divide
    do_op(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);   // 7 / -2
    do_op(4'd3, 32'h8000_0000, 32'd0, 1'b0, 1'b0);   // signed divide by zero

    reset_mid_div();
    do_op(4'd1, 32'd1234, 32'd5678, 1'b0, 1'b0);

    // madd / maddu (no-ops when the feature is compiled out)
    do_op(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    do_op(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    do_op(4'd10, 32'd1, 32'd1, 1'b1, 1'b0);
    do_op(4'd9, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);

    // Randomized phase
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = op_tab[$urandom_range(0, 12)];
      a  = $urandom;
      b  = $urandom;
      if (op == 4'd3 || op == 4'd4) begin
        case ($urandom_range(0, 7))
          0: b = 32'd0;
          1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          2: b = b & 32'h0000_00FF;
          default: ;
        endcase
      end
      do_op(op, a, b, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(posedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Execute-stage multiply/divide unit sequencer: owns HI/LO, runs mult/multu/div/divu with fixed multi-cycle latency, and generates the decode-stage stall for any MD-class instruction while the unit is occupied.
- Sits beside the E-stage ALU. Consumes the decode MD flag and the E-stage operation code/operands. Returns HI/LO read data to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mdOp  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, others none
- start  in  1  E-stage instruction valid this cycle (not a bubble)
- srcA  in  32  rs operand (forwarded)
- srcB  in  32  rt operand (forwarded)
- dMD  in  1  D-stage instruction is MD-class
- busy  out  1  unit running an operation
- mdStall  out  1  stall request to D stage
- mdOut  out  32  HI/LO read data
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, hi=0, lo=0, temp registers 0, busy=0. mdStall=0 unless dMD & launch.
- States:
  - IDLE: launch = start & mdOp in {1,2,3,4} (plus {9,10} with feature). On launch, compute the full result from srcA/srcB that cycle into tempHi/tempLo, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
  - RUN: busy=1; counter decrements each cycle. At the edge where counter==1: hi<=tempHi, lo<=tempLo, counter<=0, go to IDLE.
  - Net effect: busy is high for exactly N cycles starting the cycle after launch. New HI/LO are visible the same cycle busy falls.
- Arithmetic:
  - mult: signed 32x32->64. multu: unsigned. {hi,lo} = product.
  - div: signed; lo=quotient, hi=remainder (sign of dividend, truncate toward zero). divu: unsigned.
  - Divide by zero: unit still goes busy for DIV_CYCLES, but hi/lo are unchanged at commit.
  - 0x80000000 / -1 (signed): lo=0x80000000, hi=0.
- mthi/mtlo (start & mdOp 7/8, state IDLE): hi or lo <= srcA at that edge; no busy.
- Starts in RUN: any start in RUN (arith or mthi/mtlo) is ignored. The stall makes this unreachable in a legal pipeline, but the block must not corrupt state.
- mdOut is combinational: mdOp 5 -> hi, 6 -> lo, else 0. It shows committed values only, never temps.
- mdStall = dMD & (busy | launch). This is combinational, with no registered delay.
- Reset mid-RUN aborts immediately: busy=0, hi/lo=0, pending result discarded.
- Counter width is 4 bits; no wrap (it is loaded at launch, not free-running).

Optional Feature:
- Macro: MD_SCHEDULER_MADD_EN
- Defined: mdOp 9 (madd, signed) and 10 (maddu, unsigned) launch like mult with MULT_CYCLES latency. tempHi/tempLo = {hi,lo} + product, where {hi,lo} are the values at launch. The 64-bit sum wraps modulo 2^64.
- Undefined: mdOp 9/10 are treated as none (no launch, no stall contribution, no state change).

Test Plan:
- mult: reset, then start mult with srcA=0xFFFFFFFE (-2), srcB=3 -> busy high 5 cycles; on busy fall hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div: start div with srcA=-7 (0xFFFFFFF9), srcB=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 with prior hi=1, lo=2 -> busy 10 cycles, hi=1, lo=2 unchanged.
- Stall: dMD=1 in the launch cycle and on each of the 5 busy cycles -> mdStall=1 for 6 cycles, then 0. dMD=1 with unit idle and no launch -> mdStall=0.
- mthi/mflo: mthi srcA=0x12345678 -> hi updates next edge, busy stays 0. mdOp=5 -> mdOut=0x12345678. Next, mult issued while busy (forced start) -> ignored, and the original result commits.
- Reset mid-op: reset=0 asynchronously at the 3rd busy cycle of a div -> busy, hi, lo drop to 0 immediately. After release, a new mult completes normally.
- MADD (with MD_SCHEDULER_MADD_EN): hi=0, lo=0xFFFFFFFF, maddu 1*1 -> hi=1, lo=0 after 5 cycles. Without the macro, same stimulus -> busy stays 0 and hi/lo unchanged.
